// File: rtl/bram_arbiter.sv
// Two-requester arbiter (Z80 CPU and host loader) in front of a single-port synchronous block RAM.
// Optional macro BRAM_ARB_OOB_CHECK_EN blocks out-of-range writes, returns 0xFF for such reads and flags err_oob.
module bram_arbiter #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 15360,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_din,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_dout,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_din,
  input  logic                  ldr_lock,
  output logic                  ldr_gnt,
  output logic                  ldr_rvalid,
  output logic [DATA_WIDTH-1:0] ldr_dout,
  output logic                  lock_active,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  err_oob
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]         STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [ADDR_WIDTH:0]   DEPTH_L    = (ADDR_WIDTH + 1)'(MEM_DEPTH);
`ifdef BRAM_ARB_OOB_CHECK_EN
  localparam logic OOB_EN = 1'b1;
`else
  localparam logic OOB_EN = 1'b0;
`endif

  typedef enum logic {ST_NORMAL, ST_LOCKED} state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  cpu_rvalid_q, cpu_rvalid_d;
  logic                  ldr_rvalid_q, ldr_rvalid_d;
  logic                  rd_oob_q, rd_oob_d;
  logic                  err_oob_q, err_oob_d;
  logic [DATA_WIDTH-1:0] cpu_dout_q, cpu_dout_d;
  logic [DATA_WIDTH-1:0] ldr_dout_q, ldr_dout_d;

  logic                  cpu_win, ldr_win, any_win, win_we, win_oob;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_din;

  function automatic logic is_oob(input logic [ADDR_WIDTH-1:0] a);
    return OOB_EN && ({1'b0, a} >= DEPTH_L);
  endfunction

  // Arbitration: the lock only takes effect once the FSM has registered it.
  always_comb begin
    cpu_win = 1'b0;
    ldr_win = 1'b0;
    if (state_q == ST_LOCKED) begin
      ldr_win = ldr_req;
    end else if (cpu_req && ldr_req) begin
      if (starve_q == STARVE_LIM) ldr_win = 1'b1;
      else                        cpu_win = 1'b1;
    end else begin
      cpu_win = cpu_req;
      ldr_win = ldr_req;
    end
    any_win  = cpu_win | ldr_win;
    win_addr = ldr_win ? ldr_addr : cpu_addr;
    win_din  = ldr_win ? ldr_din  : cpu_din;
    win_we   = ldr_win ? ldr_we   : cpu_we;
    win_oob  = any_win & is_oob(win_addr);
  end

  always_comb begin
    ram_addr_d   = any_win ? win_addr : ram_addr_q;
    ram_din_d    = any_win ? win_din  : ram_din_q;
    cpu_rvalid_d = cpu_win & ~cpu_we;
    ldr_rvalid_d = ldr_win & ~ldr_we;
    rd_oob_d     = win_oob;
    err_oob_d    = err_oob_q | win_oob;
    state_d      = ldr_lock ? ST_LOCKED : ST_NORMAL;

    starve_d = '0;
    if (state_q == ST_NORMAL && ldr_req && !ldr_win)
      starve_d = (starve_q == STARVE_LIM) ? STARVE_LIM : starve_q + 1'b1;

    // Read data is only taken from the RAM in the cycle it is valid; otherwise hold.
    cpu_dout_d = cpu_dout_q;
    if (cpu_rvalid_q) cpu_dout_d = rd_oob_q ? '1 : ram_dout;
    ldr_dout_d = ldr_dout_q;
    if (ldr_rvalid_q) ldr_dout_d = rd_oob_q ? '1 : ram_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_NORMAL;
      starve_q     <= '0;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      cpu_rvalid_q <= 1'b0;
      ldr_rvalid_q <= 1'b0;
      rd_oob_q     <= 1'b0;
      err_oob_q    <= 1'b0;
      cpu_dout_q   <= '0;
      ldr_dout_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      ram_addr_q   <= ram_addr_d;
      ram_din_q    <= ram_din_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      ldr_rvalid_q <= ldr_rvalid_d;
      rd_oob_q     <= rd_oob_d;
      err_oob_q    <= err_oob_d;
      cpu_dout_q   <= cpu_dout_d;
      ldr_dout_q   <= ldr_dout_d;
    end
  end

  // Combinational outputs are masked while rst is high so they read as reset values at once.
  assign cpu_gnt     = cpu_win & ~rst;
  assign ldr_gnt     = ldr_win & ~rst;
  assign ram_we      = any_win & win_we & ~win_oob & ~rst;
  assign ram_addr    = rst ? '0 : ram_addr_d;
  assign ram_din     = rst ? '0 : ram_din_d;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign ldr_rvalid  = ldr_rvalid_q;
  assign cpu_dout    = cpu_dout_d;
  assign ldr_dout    = ldr_dout_d;
  assign lock_active = (state_q == ST_LOCKED);
  assign err_oob     = err_oob_q;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: vector table plus starvation, lock, burst, reset and range sequences.
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
  logic [13:0] cpu_addr, ldr_addr;
  logic [7:0]  cpu_din, ldr_din;
  logic        cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, lock_active, ram_we, err_oob;
  logic [7:0]  cpu_dout, ldr_dout, ram_din, ram_dout;
  logic [13:0] ram_addr;
  logic [7:0]  mem [0:16383];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bram_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_dout(cpu_dout),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_din(ldr_din),
    .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_dout(ldr_dout),
    .lock_active(lock_active), .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .ram_dout(ram_dout), .err_oob(err_oob)
  );

  // Synchronous-read block RAM model
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic        creq, cwe;
    logic [13:0] caddr;
    logic [7:0]  cdin;
    logic        lreq, lwe;
    logic [13:0] laddr;
    logic [7:0]  ldin;
    logic        lock;
    logic        e_cgnt, e_lgnt, e_we;
    logic [13:0] e_addr;
    logic        e_crv;
    logic [7:0]  e_cdout;
    logic        e_lrv;
    logic [7:0]  e_ldout;
    logic        e_lock;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [13:0] caddr,
                       input logic [7:0] cdin, input logic lreq, input logic lwe,
                       input logic [13:0] laddr, input logic [7:0] ldin, input logic lock);
    @(negedge clk);
    cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_din = cdin;
    ldr_req = lreq; ldr_we = lwe; ldr_addr = laddr; ldr_din = ldin; ldr_lock = lock;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 14'h0, 8'h0, 0, 0, 14'h0, 8'h0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_din = '0;
    ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_din = '0; ldr_lock = 0;

    vecs[0] = '{0,0,14'h000,8'h00, 0,0,14'h000,8'h00, 0, 0,0,0,14'h000, 0,8'h00, 0,8'h00, 0};
    vecs[1] = '{0,0,14'h000,8'h00, 1,1,14'h100,8'h5A, 0, 0,1,1,14'h100, 0,8'h00, 0,8'h00, 0};
    vecs[2] = '{1,0,14'h100,8'h00, 0,0,14'h000,8'h00, 0, 1,0,0,14'h100, 0,8'h00, 0,8'h00, 0};
    vecs[3] = '{0,0,14'h000,8'h00, 0,0,14'h000,8'h00, 0, 0,0,0,14'h100, 1,8'h5A, 0,8'h00, 0};
    vecs[4] = '{0,0,14'h000,8'h00, 0,0,14'h000,8'h00, 0, 0,0,0,14'h100, 0,8'h5A, 0,8'h00, 0};
    vecs[5] = '{1,1,14'h200,8'h33, 1,0,14'h100,8'h00, 0, 1,0,1,14'h200, 0,8'h5A, 0,8'h00, 0};
    vecs[6] = '{0,0,14'h000,8'h00, 1,0,14'h100,8'h00, 0, 0,1,0,14'h100, 0,8'h5A, 0,8'h00, 0};
    vecs[7] = '{0,0,14'h000,8'h00, 0,0,14'h000,8'h00, 0, 0,0,0,14'h100, 0,8'h5A, 1,8'h5A, 0};
    vecs[8] = '{0,0,14'h000,8'h00, 1,0,14'h200,8'h00, 0, 0,1,0,14'h200, 0,8'h5A, 0,8'h5A, 0};
    vecs[9] = '{0,0,14'h000,8'h00, 0,0,14'h000,8'h00, 0, 0,0,0,14'h200, 0,8'h5A, 1,8'h33, 0};

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_ldr_gnt", ldr_gnt, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_ldr_rvalid", ldr_rvalid, 0);
    chk("rst_lock", lock_active, 0);
    chk("rst_err", err_oob, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_cpu_dout", cpu_dout, 0);
    chk("rst_ldr_dout", ldr_dout, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cdin,
            vecs[i].lreq, vecs[i].lwe, vecs[i].laddr, vecs[i].ldin, vecs[i].lock);
      chk($sformatf("v%0d_cpu_gnt", i), cpu_gnt, vecs[i].e_cgnt);
      chk($sformatf("v%0d_ldr_gnt", i), ldr_gnt, vecs[i].e_lgnt);
      chk($sformatf("v%0d_ram_we", i), ram_we, vecs[i].e_we);
      chk($sformatf("v%0d_ram_addr", i), ram_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_cpu_rvalid", i), cpu_rvalid, vecs[i].e_crv);
      chk($sformatf("v%0d_cpu_dout", i), cpu_dout, vecs[i].e_cdout);
      chk($sformatf("v%0d_ldr_rvalid", i), ldr_rvalid, vecs[i].e_lrv);
      chk($sformatf("v%0d_ldr_dout", i), ldr_dout, vecs[i].e_ldout);
      chk($sformatf("v%0d_lock", i), lock_active, vecs[i].e_lock);
    end

    // Starvation: both held, loader forced through on every fifth cycle
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 14'h010, 8'h00, 1, 0, 14'h011, 8'h00, 0);
      chk($sformatf("starve%0d_ldr_gnt", k), ldr_gnt, (k % 5 == 4));
      chk($sformatf("starve%0d_cpu_gnt", k), cpu_gnt, (k % 5 != 4));
    end
    idle();

    // Lock entry during CPU read traffic
    drive(1, 0, 14'h100, 8'h00, 0, 0, 14'h000, 8'h00, 1);
    chk("lock_entry_cpu_gnt", cpu_gnt, 1);
    chk("lock_entry_active", lock_active, 0);
    drive(1, 0, 14'h100, 8'h00, 0, 0, 14'h000, 8'h00, 1);
    chk("lock_cpu_gnt", cpu_gnt, 0);
    chk("lock_active", lock_active, 1);
    chk("lock_inflight_rvalid", cpu_rvalid, 1);
    chk("lock_inflight_dout", cpu_dout, 8'h5A);
    for (int i = 0; i < 256; i++) begin
      drive(1, 0, 14'h100, 8'h00, 1, 1, 14'(i), 8'(i), 1);
      chk($sformatf("burst%0d_ldr_gnt", i), ldr_gnt, 1);
      chk($sformatf("burst%0d_cpu_gnt", i), cpu_gnt, 0);
    end
    drive(1, 0, 14'h100, 8'h00, 0, 0, 14'h000, 8'h00, 0);
    chk("unlock_edge_cpu_gnt", cpu_gnt, 0);
    chk("unlock_edge_active", lock_active, 1);
    drive(1, 0, 14'h100, 8'h00, 0, 0, 14'h000, 8'h00, 0);
    chk("unlock_cpu_gnt", cpu_gnt, 1);
    chk("unlock_active", lock_active, 0);

    // CPU readback of the burst, one grant per cycle
    for (int i = 0; i <= 256; i++) begin
      if (i < 256) drive(1, 0, 14'(i), 8'h00, 0, 0, 14'h000, 8'h00, 0);
      else         idle();
      chk($sformatf("rb%0d_cpu_gnt", i), cpu_gnt, (i < 256));
      chk($sformatf("rb%0d_rvalid", i), cpu_rvalid, 1);
      chk($sformatf("rb%0d_dout", i), cpu_dout, (i == 0) ? 8'h5A : 8'(i - 1));
    end
    idle();

    // Reset right after a CPU read grant
    drive(1, 0, 14'h100, 8'h00, 0, 0, 14'h000, 8'h00, 0);
    chk("rstmid_gnt", cpu_gnt, 1);
    #1 rst = 1'b1;
    #1;
    chk("rstmid_gnt_off", cpu_gnt, 0);
    chk("rstmid_dout", cpu_dout, 0);
    chk("rstmid_ram_addr", ram_addr, 0);
    @(negedge clk); #1;
    chk("rstmid_rvalid", cpu_rvalid, 0);
    rst = 1'b0;
    cpu_req = 1'b0;
    drive(1, 0, 14'h100, 8'h00, 0, 0, 14'h000, 8'h00, 0);
    chk("reissue_gnt", cpu_gnt, 1);
    chk("reissue_rvalid0", cpu_rvalid, 0);
    idle();
    chk("reissue_rvalid", cpu_rvalid, 1);
    chk("reissue_dout", cpu_dout, 8'h5A);

    // Access above the implemented depth
    drive(1, 1, 14'h3C00, 8'h11, 0, 0, 14'h000, 8'h00, 0);
    chk("oob_wr_gnt", cpu_gnt, 1);
`ifdef BRAM_ARB_OOB_CHECK_EN
    chk("oob_wr_ram_we", ram_we, 0);
    drive(1, 0, 14'h3C00, 8'h00, 0, 0, 14'h000, 8'h00, 0);
    chk("oob_rd_gnt", cpu_gnt, 1);
    chk("oob_err_set", err_oob, 1);
    idle();
    chk("oob_rvalid", cpu_rvalid, 1);
    chk("oob_dout", cpu_dout, 8'hFF);
    idle();
    chk("oob_err_sticky", err_oob, 1);
`else
    chk("oob_wr_ram_we", ram_we, 1);
    drive(1, 0, 14'h3C00, 8'h00, 0, 0, 14'h000, 8'h00, 0);
    chk("oob_rd_gnt", cpu_gnt, 1);
    chk("oob_err_tied", err_oob, 0);
    idle();
    chk("oob_rvalid", cpu_rvalid, 1);
    chk("oob_dout", cpu_dout, 8'h11);
    chk("oob_err_tied2", err_oob, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-port arbiter that shares the single-port 15 KiB on-chip block RAM (8-bit data, 14-bit address, synchronous read) between the Z80 CPU bus and the host loader/debug port.
- Each requester gets a req/gnt handshake and a registered read return.
- Includes a starvation guard and a loader lock mode that gives the loader exclusive access, used for ROM image loading while the CPU is held off.
- Sits between the Z80 memory-bus adapter and the loader on one side, and the block RAM on the other.

Parameters:
- ADDR_WIDTH, 14, address width of RAM and both requesters
- DATA_WIDTH, 8, data width
- MEM_DEPTH, 15360, number of implemented words; addresses >= MEM_DEPTH are out of range
- STARVE_MAX, 4, consecutive denied loader cycles before the loader is forced to win

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read; valid with cpu_req
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_din  in  DATA_WIDTH  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_dout  out  DATA_WIDTH  CPU read data
- ldr_req  in  1  loader access request, held until ldr_gnt
- ldr_we  in  1  loader write enable
- ldr_addr  in  ADDR_WIDTH  loader address
- ldr_din  in  DATA_WIDTH  loader write data
- ldr_lock  in  1  request exclusive loader ownership
- ldr_gnt  out  1  loader access performed this cycle
- ldr_rvalid  out  1  loader read data valid
- ldr_dout  out  DATA_WIDTH  loader read data
- lock_active  out  1  arbiter is in LOCKED state
- ram_addr  out  ADDR_WIDTH  to block RAM address
- ram_din  out  DATA_WIDTH  to block RAM data in
- ram_we  out  1  to block RAM write enable
- ram_dout  in  DATA_WIDTH  from block RAM, valid one cycle after address
- err_oob  out  1  sticky out-of-range access flag

Behaviour:
- Reset values: all gnt, rvalid, lock_active, err_oob and ram_we = 0; all dout, ram_addr and ram_din = 0; FSM = NORMAL; starve counter = 0.
- Grant timing: combinational in the request cycle N. The winner's addr/din/we drive ram_* in cycle N; the RAM samples them at the end of N.
- Read return: for a granted read, the owner's rvalid is registered high in N+1 for exactly one cycle, with dout = ram_dout. Writes never raise rvalid. dout holds its last value when rvalid = 0.
- Read latency: 1 cycle from grant to rvalid. One access per cycle in total, so back-to-back grants give full throughput.
- Non-granted cycles: ram_we = 0 and ram_addr holds its previous value.
- FSM, NORMAL:
  - Only one requester active: it is granted.
  - Both active: CPU wins unless starve == STARVE_MAX, in which case the loader wins.
  - Starve counter: increments (saturating at STARVE_MAX) each cycle ldr_req is denied; clears when the loader is granted or ldr_req = 0.
  - ldr_lock = 1 at an edge: go to LOCKED.
- FSM, LOCKED:
  - lock_active = 1.
  - cpu_gnt is always 0; only the loader is granted.
  - A CPU read already in flight still completes its rvalid.
  - ldr_lock = 0 at an edge: go to NORMAL with starve counter = 0.
- Lock entry timing: when ldr_lock rises, normal arbitration still applies in that same cycle; exclusivity starts the next cycle.
- Read-during-write: not possible, since there is only one access per cycle.
- Reset mid-operation: a pending rvalid is dropped and its read data lost; requesters must reissue.
- Address arithmetic: no wrap; addresses are passed unmodified (subject to the optional feature).

Optional Feature:
- Macro: BRAM_ARB_OOB_CHECK_EN.
- Defined:
  - A granted access with addr >= MEM_DEPTH still receives gnt, but ram_we is forced to 0.
  - A read returns dout = all-ones (0xFF) with normal rvalid timing.
  - err_oob is set the following cycle and stays set until rst.
- Undefined: addresses are passed straight to the RAM and err_oob is tied 0.

Test Plan:
- Loader writes 0x5A to 0x0100, then the CPU reads 0x0100 -> ldr_gnt in the request cycle; cpu_rvalid exactly 1 cycle after cpu_gnt with cpu_dout = 0x5A.
- cpu_req and ldr_req held continuously with STARVE_MAX = 4 -> CPU granted 4 cycles, loader on the 5th, pattern repeats; no cycle without a grant.
- Assert ldr_lock during CPU read traffic -> in-flight CPU rvalid completes; cpu_gnt = 0 and lock_active = 1 from the next cycle; on ldr_lock release, cpu_gnt resumes the following cycle.
- Loader burst-writes 0x00..0xFF to 0x0000..0x00FF in LOCKED, then the CPU reads back -> all 256 bytes match, one grant per cycle.
- With BRAM_ARB_OOB_CHECK_EN defined, CPU write 0x11 to 0x3C00 then read 0x3C00 -> ram_we stays 0, cpu_dout = 0xFF, err_oob = 1 until rst.
- Assert rst the cycle after a CPU read grant -> cpu_rvalid never rises, all outputs reach reset values immediately; the request reissued after rst deasserts completes normally.
